// File: rtl/unid_controle.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with decoded strobes.
// Optional memory stall handshake enabled with `define UNID_CONTROLE_STALL_EN (adds mem_ready).
module unid_controle #(
   parameter int FUNC_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic              z_flag,
`ifdef UNID_CONTROLE_STALL_EN
   input  logic              mem_ready,
`endif
   output logic [FUNC_W-1:0] ula_func,
   output logic              ula_src_b,
   output logic              ir_write,
   output logic              pc_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              reg_write,
   output logic              reg_dst,
   output logic              mem_to_reg,
   output logic              illegal,
   output logic [1:0]        pc_src,
   output logic [2:0]        state
);

   // state  | meaning
   // FETCH  | read instruction, latch op/fn, PC <= PC+4
   // DECODE | J jumps, illegal op flagged, others go to EXEC
   // EXEC   | ALU operation, BEQ resolves the branch
   // MEM    | LW read / SW write
   // WB     | register file write
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   state_t     state_q;
   logic [5:0] op_q;
   logic [2:0] fn_q;
   logic       mem_rdy;
   logic       op_legal;
   logic       instr_unused;

`ifdef UNID_CONTROLE_STALL_EN
   assign mem_rdy = mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   assign instr_unused = ^instr[25:3];
   assign op_legal = (op_q inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= 6'd0;
         fn_q    <= 3'd0;
      end else begin
         case (state_q)
            FETCH: begin
               if (mem_rdy) begin
                  op_q    <= instr[31:26];
                  fn_q    <= instr[2:0];
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               if (op_q == OP_J || !op_legal) state_q <= FETCH;
               else                            state_q <= EXEC;
            end
            EXEC: begin
               case (op_q)
                  OP_R, OP_ADDI: state_q <= WB;
                  OP_LW, OP_SW:  state_q <= MEM;
                  default:       state_q <= FETCH;
               endcase
            end
            MEM: begin
               if (mem_rdy) state_q <= (op_q == OP_LW) ? WB : FETCH;
            end
            WB:      state_q <= FETCH;
            default: state_q <= FETCH;
         endcase
      end
   end

   // Outputs are gated by rst so no strobe can fire while reset is being applied.
   always_comb begin
      ula_func   = '0;
      ula_src_b  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      pc_src     = 2'b00;
      state      = rst ? 3'd0 : state_q;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               mem_read = 1'b1;
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
            DECODE: begin
               if (op_q == OP_J) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b10;
               end else if (!op_legal) begin
                  illegal = 1'b1;
               end
            end
            EXEC: begin
               case (op_q)
                  OP_R:                  ula_func = FUNC_W'(fn_q);
                  OP_BEQ:                ula_func = FUNC_W'(3'd1);
                  default:               ula_func = '0;
               endcase
               ula_src_b = (op_q inside {OP_ADDI, OP_LW, OP_SW});
               if (op_q == OP_BEQ) begin
                  pc_src   = 2'b01;
                  pc_write = z_flag;
               end
            end
            MEM: begin
               mem_read  = (op_q == OP_LW);
               mem_write = (op_q == OP_SW);
            end
            WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (op_q == OP_LW);
               reg_dst    = (op_q == OP_R);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unid_controle.sv
// Self-checking bench for unid_controle: directed table, reset corner cases, random instructions.
module tb_unid_controle;
   localparam int FUNC_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       instr = 32'd0;
   logic              z_flag = 1'b0;
`ifdef UNID_CONTROLE_STALL_EN
   logic              mem_ready = 1'b1;
`endif
   logic [FUNC_W-1:0] ula_func;
   logic              ula_src_b, ir_write, pc_write, mem_read, mem_write;
   logic              reg_write, reg_dst, mem_to_reg, illegal;
   logic [1:0]        pc_src;
   logic [2:0]        state;

   unid_controle #(.FUNC_W(FUNC_W)) dut (
      .clk(clk), .rst(rst), .instr(instr), .z_flag(z_flag),
`ifdef UNID_CONTROLE_STALL_EN
      .mem_ready(mem_ready),
`endif
      .ula_func(ula_func), .ula_src_b(ula_src_b), .ir_write(ir_write),
      .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .pc_src(pc_src), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] fn;
      logic       sb, irw, pcw, mr, mw, rw, rd, m2r, ill;
      logic [1:0] ps;
   } ov_t;

   typedef struct {
      string       nm;
      logic [31:0] iw;
      logic        z;
      int          len;
      logic [23:0] sts;
   } vec_t;

   int  n_cmp = 0;
   int  n_bad = 0;
   ov_t expq[$];

   function automatic ov_t dut_ov();
      ov_t r;
      r.st = state; r.fn = ula_func; r.sb = ula_src_b; r.irw = ir_write;
      r.pcw = pc_write; r.mr = mem_read; r.mw = mem_write; r.rw = reg_write;
      r.rd = reg_dst; r.m2r = mem_to_reg; r.ill = illegal; r.ps = pc_src;
      return r;
   endfunction

   task automatic check(input string nm, input ov_t exp);
      ov_t got;
      got = dut_ov();
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h required %h", nm, $time, got, exp);
      end
   endtask

   // Reference: per-instruction list of the cycles it occupies and what each cycle drives.
   task automatic model(input logic [31:0] iw, input logic z);
      logic [5:0] op;
      ov_t        r;
      op = iw[31:26];
      expq.delete();
      r = '0; r.st = 3'd0; r.irw = 1'b1; r.pcw = 1'b1; r.mr = 1'b1;
      expq.push_back(r);
      r = '0; r.st = 3'd1;
      if (op == 6'h02) begin
         r.pcw = 1'b1; r.ps = 2'b10; expq.push_back(r); return;
      end
      if (!(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04})) begin
         r.ill = 1'b1; expq.push_back(r); return;
      end
      expq.push_back(r);
      r = '0; r.st = 3'd2;
      r.fn = (op == 6'h00) ? iw[2:0] : (op == 6'h04) ? 3'd1 : 3'd0;
      r.sb = (op inside {6'h08, 6'h23, 6'h2B});
      if (op == 6'h04) begin r.ps = 2'b01; r.pcw = z; end
      expq.push_back(r);
      if (op == 6'h04) return;
      if (op inside {6'h23, 6'h2B}) begin
         r = '0; r.st = 3'd3; r.mr = (op == 6'h23); r.mw = (op == 6'h2B);
         expq.push_back(r);
         if (op == 6'h2B) return;
      end
      r = '0; r.st = 3'd4; r.rw = 1'b1; r.m2r = (op == 6'h23); r.rd = (op == 6'h00);
      expq.push_back(r);
   endtask

   // Called just after a rising edge with the DUT in FETCH; returns after it is back in FETCH.
   task automatic run_instr(input string nm, input logic [31:0] iw, input logic z,
                            output int len, output logic [23:0] sts);
      model(iw, z);
      len = 0;
      sts = '0;
      do begin
         instr  = (len == 0) ? iw : $urandom;
         z_flag = z;
         @(negedge clk);
         if (len < expq.size()) check(nm, expq[len]);
         else begin
            n_cmp++; n_bad++;
            $display("FAIL %s overrun: cycle %0d state %0d, required FETCH after %0d cycles",
                     nm, len, state, expq.size());
         end
         sts[len*3 +: 3] = state;
         len++;
         @(posedge clk); #1;
      end while (state != 3'd0 && len < 8);
      n_cmp++;
      if (len != expq.size()) begin
         n_bad++;
         $display("FAIL %s latency: got %0d required %0d", nm, len, expq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[9];
      int          len;
      logic [23:0] sts;
      logic [31:0] rnd;
      logic [5:0]  op;
      logic [5:0]  ops[6];

      tbl[0] = '{"sub",  32'h00000001, 1'b0, 4, {12'd0, 3'd4, 3'd2, 3'd1, 3'd0}};
      tbl[1] = '{"lw",   32'h8C000004, 1'b0, 5, {9'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
      tbl[2] = '{"beq1", 32'h10000000, 1'b1, 3, {15'd0, 3'd2, 3'd1, 3'd0}};
      tbl[3] = '{"beq0", 32'h10000000, 1'b0, 3, {15'd0, 3'd2, 3'd1, 3'd0}};
      tbl[4] = '{"j",    32'h08000000, 1'b0, 2, {18'd0, 3'd1, 3'd0}};
      tbl[5] = '{"ill",  32'hFC000000, 1'b1, 2, {18'd0, 3'd1, 3'd0}};
      tbl[6] = '{"sw",   32'hAC000000, 1'b0, 4, {12'd0, 3'd3, 3'd2, 3'd1, 3'd0}};
      tbl[7] = '{"addi", 32'h20000005, 1'b0, 4, {12'd0, 3'd4, 3'd2, 3'd1, 3'd0}};
      tbl[8] = '{"and",  32'h00000006, 1'b1, 4, {12'd0, 3'd4, 3'd2, 3'd1, 3'd0}};
      ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};

      // held in reset: everything low, even with a legal instruction presented
      rst = 1'b1;
      instr = 32'h00000001;
      repeat (2) begin
         @(negedge clk);
         check("reset_outputs", '0);
         instr = $urandom;
      end
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_instr(tbl[i].nm, tbl[i].iw, tbl[i].z, len, sts);
         n_cmp++;
         if (len != tbl[i].len || sts != tbl[i].sts) begin
            n_bad++;
            $display("FAIL %s sequence: got len %0d states %h required len %0d states %h",
                     tbl[i].nm, len, sts, tbl[i].len, tbl[i].sts);
         end
      end

      // reset asserted during SW's MEM cycle
      model(32'hAC000000, 1'b0);
      for (int c = 0; c < 3; c++) begin
         instr = (c == 0) ? 32'hAC000000 : $urandom;
         @(negedge clk);
         check("sw_pre_reset", expq[c]);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      check("reset_in_mem", '0);
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if (state !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_in_mem_next: state %0d required 0", state);
      end
      run_instr("after_reset", 32'h00000001, 1'b0, len, sts);

`ifdef UNID_CONTROLE_STALL_EN
      model(32'h00000001, 1'b0);
      mem_ready = 1'b0;
      repeat (3) begin
         instr = 32'hFC000000;
         @(negedge clk);
         check("fetch_stall", expq[0]);
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      run_instr("post_stall_sub", 32'h00000001, 1'b0, len, sts);
`endif

      for (int k = 0; k < 40; k++) begin
         rnd = $urandom;
         if ($urandom_range(0, 6) == 0) op = rnd[31:26];
         else op = ops[$urandom_range(0, 5)];
         run_instr("random", {op, rnd[25:0]}, 1'($urandom_range(0, 1)), len, sts);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unid_controle.md
UNID_CONTROLE -- requirements
Module: unid_controle

Interface
REQ-001 Parameter FUNC_W, default 3, SHALL set the width of ula_func.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 instr  in  32  instruction word from memory, valid during FETCH.
REQ-005 z_flag  in  1  zero flag from the ALU, sampled in EXEC.
REQ-006 ula_func  out  FUNC_W  ALU operation: 000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA, 101 OR, 110 AND, 111 XOR.
REQ-007 ula_src_b  out  1  ALU B select: 0 = register rt, 1 = sign-extended instr[15:0].
REQ-008 Single-bit outputs SHALL be ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst (1 = rd, 0 = rt), mem_to_reg and illegal (one-cycle pulse).
REQ-009 pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-010 state  out  3  current state code, for debug.

Function
REQ-011 The FSM SHALL have five states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-012 On the FETCH->DECODE edge the block SHALL latch instr[31:26] as op and instr[2:0] as fn; both SHALL hold until the next FETCH.
REQ-013 Decoded ops SHALL be: 0x00 R-type, 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J; any other op is illegal.
REQ-014 FETCH SHALL assert mem_read=1, ir_write=1, pc_write=1 and pc_src=00, then go to DECODE.
REQ-015 DECODE with J SHALL assert pc_write=1 and pc_src=10, then go to FETCH.
REQ-016 DECODE with an illegal op SHALL pulse illegal=1 for one cycle, then go to FETCH; no other write strobe SHALL assert.
REQ-017 DECODE with any other legal op SHALL go to EXEC.
REQ-018 In EXEC, ula_func SHALL be: fn for R-type; 000 for ADDI, LW and SW; 001 for BEQ.
REQ-019 In EXEC, ula_src_b SHALL be 1 for ADDI, LW and SW, and 0 otherwise.
REQ-020 EXEC transitions: R-type and ADDI -> WB; LW and SW -> MEM; BEQ -> FETCH.
REQ-021 EXEC with BEQ SHALL drive pc_src=01 and pc_write=z_flag, with z_flag sampled combinationally in that cycle.
REQ-022 MEM with LW SHALL assert mem_read=1, then go to WB.
REQ-023 MEM with SW SHALL assert mem_write=1, then go to FETCH.
REQ-024 WB SHALL assert reg_write=1, with mem_to_reg=1 only for LW and reg_dst=1 only for R-type, then go to FETCH.
REQ-025 All outputs SHALL be combinational from state and the latched op/fn.
REQ-026 An output not named for a state SHALL be 0 in that state; ula_func SHALL be 000 outside EXEC.
REQ-027 Write strobes (pc_write, mem_write, reg_write, ir_write) SHALL never assert in the same cycle as rst=1.
REQ-028 Instruction latency SHALL be: J 2 cycles; BEQ 3; R-type and ADDI 4; SW 4; LW 5.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=FETCH and op=fn=0, overriding every transition including mid-instruction.
REQ-030 While rst=1, all outputs SHALL be 0, including FETCH strobes.
REQ-031 The first FETCH strobes SHALL appear in the first cycle after rst deasserts.

Configuration
REQ-032 With UNID_CONTROLE_STALL_EN defined, a 1-bit input mem_ready SHALL exist.
REQ-033 With the macro defined, FETCH and MEM SHALL hold their state and strobes while mem_ready=0.
REQ-034 With the macro defined, op/fn SHALL latch only on the FETCH edge where mem_ready=1.
REQ-035 With UNID_CONTROLE_STALL_EN undefined, mem_ready SHALL be absent and memory SHALL be treated as always ready.

Verification
REQ-036 Release rst, then instr=0x00000001 (SUB) -> state sequence 0,1,2,4,0; ula_func=001 in EXEC; reg_write=1 with reg_dst=1 in WB.
REQ-037 LW (instr=0x8C000004) -> states 0,1,2,3,4; mem_read=1 in MEM; mem_to_reg=1 in WB; 5 cycles total.
REQ-038 BEQ with z_flag=1 -> pc_write=1 and pc_src=01 in EXEC; rerun with z_flag=0 -> pc_write=0; both return to FETCH.
REQ-039 op=0x3F -> illegal pulses for exactly 1 cycle in DECODE; no write strobe asserts; next state is FETCH.
REQ-040 Assert rst during the MEM state of SW -> mem_write=0 in that cycle; state=FETCH after the edge.
REQ-041 With the macro defined, hold mem_ready=0 for 3 cycles in FETCH -> state stays 0 with ir_write=1 throughout; advances when mem_ready=1.
